// File: rtl/packet_rr_arbiter_pkg.sv
// ============================================================================
// Module   : ui_arb_pkg
// Purpose  : Shared state encoding and modular index helper for the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ui_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Modular increment; the >= guard keeps any stray index inside the ring.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx >= n - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/packet_rr_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational circular first-set-bit search starting at start_i.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import ui_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [W-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = start_i;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
      cand = W'(rr_next(32'(cand), N));
    end
  end

endmodule

`default_nettype wire

// File: rtl/packet_rr_arbiter.sv
// ============================================================================
// Module   : packet_rr_arbiter
// Purpose  : Round-robin, packet-locked arbiter driving an N:1 stream mux.
//            Optional stall timeout enabled by defining ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module packet_rr_arbiter
  import ui_arb_pkg::*;
#(
  parameter int unsigned NUM_INPUTS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned WIDTH_SELECT  = $clog2(NUM_INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_INPUTS-1:0]   req_valid,
  input  logic [NUM_INPUTS-1:0]   req_last,
  output logic [NUM_INPUTS-1:0]   req_ready,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [WIDTH_SELECT-1:0] sel,
  output logic                    grant_active,
  output logic                    timeout
);

  arb_state_t              state_q;
  logic [WIDTH_SELECT-1:0] sel_q;
  logic [WIDTH_SELECT-1:0] rr_ptr_q;
  logic [WIDTH_SELECT-1:0] rr_ptr_d;
  logic                    pick_found;
  logic [WIDTH_SELECT-1:0] pick_idx;
  logic                    locked;
  logic                    beat;

  rr_pick #(
    .N (NUM_INPUTS)
  ) u_rr_pick (
    .req_i   (req_valid),
    .start_i (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign locked       = (state_q == ARB_LOCKED);
  assign out_valid    = locked & req_valid[sel_q];
  assign out_last     = locked & req_last[sel_q];
  assign req_ready    = locked ? (NUM_INPUTS'(out_ready) << sel_q) : '0;
  assign beat         = out_valid & out_ready;
  assign grant_active = locked;
  assign sel          = sel_q;
  assign rr_ptr_d     = WIDTH_SELECT'(rr_next(32'(sel_q), NUM_INPUTS));

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [STALL_W-1:0] stall_cnt_q;
  logic               timeout_q;

  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          stall_cnt_q <= '0;
          if (pick_found) begin
            sel_q   <= pick_idx;
            state_q <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          // A beat on the expiry cycle wins over the forced release.
          if (beat) begin
            stall_cnt_q <= '0;
            if (out_last) begin
              rr_ptr_q <= rr_ptr_d;
              sel_q    <= '0;
              state_q  <= ARB_IDLE;
            end
          end else if (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            stall_cnt_q <= '0;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= '0;
            state_q     <= ARB_IDLE;
            timeout_q   <= 1'b1;
          end else begin
            stall_cnt_q <= stall_cnt_q + STALL_W'(1);
          end
        end
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            sel_q   <= pick_idx;
            state_q <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          // sel returns to 0 in IDLE so every output reads 0 between packets.
          if (beat && out_last) begin
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= '0;
            state_q  <= ARB_IDLE;
          end
        end
      endcase
    end
  end
`endif

endmodule

`default_nettype wire
